lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Load/store initiator that drives the single-port byte-enable data RAM from the RV32I core's memory stage.
- Accepts one byte-addressed load/store request at a time and checks alignment and funct3.
- Converts the request into a word address, byte enables and lane-replicated write data, and issues exactly one RAM access.
- Waits for the RAM's one-cycle-later VALID, then returns sign/zero-extended load data, or a fault, to the core.

Parameters:
- DATA_WIDTH, 32, data bus width; fixed to 32 for RV32I.
- ADDR_WIDTH, 32, byte address width from the core and word address width to the RAM.
- N_COLS, 4, byte lanes; DATA_WIDTH/8, localparam.
- TIMEOUT_CYCLES, 8, maximum WAIT-state cycles without i_MEM_VALID before a bus fault is raised; must be ≥1.

Ports:
- i_CLK  in  1  clock.
- i_RST  in  1  synchronous active-high reset.
- i_REQ  in  1  core request; sampled only while o_READY=1.
- i_WE  in  1  1=store, 0=load.
- i_FUNCT3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_ADDR  in  ADDR_WIDTH  byte address.
- i_WDATA  in  DATA_WIDTH  store data, right-aligned.
- o_READY  out  1  block idle and able to accept a request.
- o_DONE  out  1  one-cycle completion pulse.
- o_RDATA  out  DATA_WIDTH  formatted load result; valid with o_DONE.
- o_MISALIGNED  out  1  misalignment exception; valid with o_DONE.
- o_FAULT  out  1  illegal funct3 or timeout; valid with o_DONE.
- o_MEM_CE  out  1  RAM chip enable.
- o_MEM_WE  out  N_COLS  RAM byte write enables.
- o_MEM_ADDR  out  ADDR_WIDTH  RAM word address.
- o_MEM_WDATA  out  DATA_WIDTH  RAM write data.
- i_MEM_RDATA  in  DATA_WIDTH  RAM read data.
- i_MEM_VALID  in  1  RAM response valid; arrives one cycle after CE is sampled.

Behaviour:

Clocking and reset:
- Single clock domain. Synchronous active-high i_RST, named as above.
- Reset takes effect at the next edge, forces state to IDLE and clears all registered outputs (o_DONE, o_RDATA, o_MISALIGNED, o_FAULT, o_MEM_*) to 0, aborting any in-flight access.
- o_READY = (state==IDLE). It is therefore 1 in the first cycle after reset deasserts.

FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: on i_REQ, latch WE, FUNCT3, ADDR, WDATA.
  - If funct3 is illegal (011/110/111, or 100/101 with i_WE=1), set the fault flag and go to RESP.
  - Else if misaligned (H with ADDR[0]=1, or W with ADDR[1:0]≠0), set the misaligned flag and go to RESP.
  - Else go to ISSUE.
  - A rejected request never asserts o_MEM_CE.
- ISSUE: lasts exactly one cycle, with o_MEM_CE=1 and the memory outputs driven. Next state is WAIT, with the timeout counter cleared.
  - o_MEM_ADDR = {2'b00, ADDR[ADDR_WIDTH-1:2]}.
  - Byte: WE = 4'b0001 << ADDR[1:0]; WDATA = {4{WDATA[7:0]}}.
  - Half: WE = 4'b0011 << ADDR[1:0]; WDATA = {2{WDATA[15:0]}}.
  - Word: WE = 4'b1111; WDATA = WDATA.
  - Loads drive WE = 0.
  - Outside ISSUE: o_MEM_CE=0 and o_MEM_WE=0.
- WAIT: count cycles.
  - On i_MEM_VALID, capture the formatted result and go to RESP. A store produces o_RDATA=0.
  - If the counter reaches TIMEOUT_CYCLES without i_MEM_VALID, set the fault flag and go to RESP.
  - If VALID arrives in the same cycle the counter hits the limit, VALID wins and no fault is raised.
- RESP: o_DONE=1 for exactly one cycle, with o_RDATA, o_MISALIGNED and o_FAULT stable; then go to IDLE. All three result outputs are cleared in every non-RESP cycle.

Load formatting:
- Shift i_MEM_RDATA right by 8*ADDR[1:0].
- LB / LH sign-extend bit 7 / bit 15.
- LBU / LHU zero-extend.
- LW passes through unchanged.

Timing and throughput:
- Nominal latency: request accepted at edge N, CE high in cycle N+1, VALID in cycle N+2, o_DONE in cycle N+3.
- Rejected requests: o_DONE in cycle N+1.
- Throughput is one request per 4 cycles. i_REQ while o_READY=0 is ignored (not queued).
- i_MEM_VALID outside WAIT is ignored.

Test Plan:
- SW addr 0x0000_0010, data 0xDEADBEEF, then LW same addr -> store issues WE=1111, MEM_ADDR=0x4, o_DONE 3 cycles after accept; load returns o_RDATA=0xDEADBEEF with no flags.
- SB 0xA5 at 0x13, then LB 0x13 and LBU 0x13 -> WE=1000, MEM_WDATA=0xA5A5A5A5; LB returns 0xFFFFFFA5, LBU returns 0x000000A5.
- SH 0x8001 at 0x22, then LH 0x22 and LHU 0x22 -> WE=1100; LH returns 0xFFFF8001, LHU returns 0x00008001.
- LW at 0x06, LH at 0x05, and SB with funct3=100 -> each gives o_DONE one cycle after accept with o_MISALIGNED=1 (first two) or o_FAULT=1 (third), and o_MEM_CE never asserted.
- RAM model holds i_MEM_VALID low -> o_DONE with o_FAULT=1 after TIMEOUT_CYCLES WAIT cycles; the next request then completes normally.
- Assert i_RST during WAIT -> next cycle o_READY=1, no o_DONE pulse, all outputs 0; a late i_MEM_VALID is ignored.

Source files
------------

// File: rtl/lsu_mem_port.sv
// RV32I load/store initiator: validates one byte-addressed request, issues a single
// access to the byte-enable data RAM, and returns formatted load data or a fault.
module lsu_mem_port #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic                    i_REQ,
  input  logic                    i_WE,
  input  logic [2:0]              i_FUNCT3,
  input  logic [ADDR_WIDTH-1:0]   i_ADDR,
  input  logic [DATA_WIDTH-1:0]   i_WDATA,
  output logic                    o_READY,
  output logic                    o_DONE,
  output logic [DATA_WIDTH-1:0]   o_RDATA,
  output logic                    o_MISALIGNED,
  output logic                    o_FAULT,
  output logic                    o_MEM_CE,
  output logic [DATA_WIDTH/8-1:0] o_MEM_WE,
  output logic [ADDR_WIDTH-1:0]   o_MEM_ADDR,
  output logic [DATA_WIDTH-1:0]   o_MEM_WDATA,
  input  logic [DATA_WIDTH-1:0]   i_MEM_RDATA,
  input  logic                    i_MEM_VALID
);

  localparam int N_COLS = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            ofs_q, ofs_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_d, mis_d, fault_d, ce_d;
  logic [DATA_WIDTH-1:0] rdata_d, wdata_d;
  logic [N_COLS-1:0]     mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;

  logic                  f3_illegal, misaligned;
  logic [N_COLS-1:0]     lane_mask;
  logic [DATA_WIDTH-1:0] wdata_rep, shifted, load_fmt;

  assign o_READY = (state_q == S_IDLE);

  // Request decode works on the live inputs: it only matters in the accept cycle.
  always_comb begin
    f3_illegal = 1'b1;
    case (i_FUNCT3)
      3'b000, 3'b001, 3'b010: f3_illegal = 1'b0;
      3'b100, 3'b101:         f3_illegal = i_WE;
      default:                f3_illegal = 1'b1;
    endcase
    misaligned = ((i_FUNCT3[1:0] == 2'b01) && i_ADDR[0]) ||
                 ((i_FUNCT3[1:0] == 2'b10) && (i_ADDR[1:0] != 2'b00));
    case (i_FUNCT3[1:0])
      2'b00: begin
        lane_mask = N_COLS'(1) << i_ADDR[1:0];
        wdata_rep = {N_COLS{i_WDATA[7:0]}};
      end
      2'b01: begin
        lane_mask = N_COLS'(3) << i_ADDR[1:0];
        wdata_rep = {(N_COLS/2){i_WDATA[15:0]}};
      end
      default: begin
        lane_mask = '1;
        wdata_rep = i_WDATA;
      end
    endcase
  end

  assign shifted = i_MEM_RDATA >> {ofs_q, 3'b000};

  // funct3[2] selects zero-extension (LBU/LHU).
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   load_fmt = {{(DATA_WIDTH-8){shifted[7] & ~funct3_q[2]}}, shifted[7:0]};
      2'b01:   load_fmt = {{(DATA_WIDTH-16){shifted[15] & ~funct3_q[2]}}, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    ofs_d      = ofs_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    rdata_d    = '0;
    mis_d      = 1'b0;
    fault_d    = 1'b0;
    ce_d       = 1'b0;
    mem_we_d   = '0;
    mem_addr_d = '0;
    wdata_d    = '0;
    case (state_q)
      S_IDLE: if (i_REQ) begin
        we_d     = i_WE;
        funct3_d = i_FUNCT3;
        ofs_d    = i_ADDR[1:0];
        if (f3_illegal) begin
          fault_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_RESP;
        end else if (misaligned) begin
          mis_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_RESP;
        end else begin
          // Memory outputs are registered here so they are visible throughout ISSUE.
          ce_d       = 1'b1;
          mem_we_d   = i_WE ? lane_mask : '0;
          mem_addr_d = {2'b00, i_ADDR[ADDR_WIDTH-1:2]};
          wdata_d    = wdata_rep;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_MEM_VALID) begin
          rdata_d = we_q ? '0 : load_fmt;
          done_d  = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          fault_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_RST) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      ofs_q        <= '0;
      cnt_q        <= '0;
      o_DONE       <= 1'b0;
      o_RDATA      <= '0;
      o_MISALIGNED <= 1'b0;
      o_FAULT      <= 1'b0;
      o_MEM_CE     <= 1'b0;
      o_MEM_WE     <= '0;
      o_MEM_ADDR   <= '0;
      o_MEM_WDATA  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      ofs_q        <= ofs_d;
      cnt_q        <= cnt_d;
      o_DONE       <= done_d;
      o_RDATA      <= rdata_d;
      o_MISALIGNED <= mis_d;
      o_FAULT      <= fault_d;
      o_MEM_CE     <= ce_d;
      o_MEM_WE     <= mem_we_d;
      o_MEM_ADDR   <= mem_addr_d;
      o_MEM_WDATA  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a small byte-enable RAM model answering
// one cycle after CE; expected values are hand-computed constants.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, done, misaligned, fault, mem_ce;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata = '0;
  logic        ram_valid = 1'b0;
  logic        valid_inj = 1'b0;
  logic        ram_mute = 1'b0;
  logic        mem_valid;
  logic [31:0] ram [0:63];

  int checks = 0;
  int errors = 0;

  assign mem_valid = ram_valid | valid_inj;

  always #5 clk = ~clk;

  lsu_mem_port #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .i_CLK(clk), .i_RST(rst), .i_REQ(req), .i_WE(we), .i_FUNCT3(funct3),
    .i_ADDR(addr), .i_WDATA(wdata), .o_READY(ready), .o_DONE(done),
    .o_RDATA(rdata), .o_MISALIGNED(misaligned), .o_FAULT(fault),
    .o_MEM_CE(mem_ce), .o_MEM_WE(mem_we), .o_MEM_ADDR(mem_addr),
    .o_MEM_WDATA(mem_wdata), .i_MEM_RDATA(mem_rdata), .i_MEM_VALID(mem_valid)
  );

  initial for (int i = 0; i < 64; i++) ram[i] = '0;

  // RAM model: samples CE at the edge and answers with VALID one cycle later.
  always @(posedge clk) begin
    ram_valid <= mem_ce && !ram_mute;
    if (mem_ce) begin
      mem_rdata <= ram[mem_addr[5:0]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request from a negedge and follows it to o_DONE (bounded).
  task automatic txn(input string tag, input logic t_we, input logic [2:0] t_f3,
                     input logic [31:0] t_addr, input logic [31:0] t_wdata,
                     input int exp_lat, input logic exp_ce, input logic [3:0] exp_mwe,
                     input logic [31:0] exp_maddr, input logic [31:0] exp_mwdata,
                     input logic [31:0] exp_rdata, input logic exp_mis, input logic exp_fault);
    int          lat;
    logic        ce_seen;
    logic [3:0]  cap_we;
    logic [31:0] cap_addr, cap_wdata;
    @(negedge clk);
    check({tag, " ready"}, 32'(ready), 32'd1);
    req = 1'b1; we = t_we; funct3 = t_f3; addr = t_addr; wdata = t_wdata;
    @(negedge clk);
    req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    check({tag, " busy"}, 32'(ready), 32'd0);
    lat = 1; ce_seen = 1'b0; cap_we = '0; cap_addr = '0; cap_wdata = '0;
    while (!done && lat < 20) begin
      if (mem_ce) begin
        ce_seen = 1'b1; cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
      end
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " ce"}, 32'(ce_seen), 32'(exp_ce));
    if (exp_ce) begin
      check({tag, " mem_we"}, 32'(cap_we), 32'(exp_mwe));
      check({tag, " mem_addr"}, cap_addr, exp_maddr);
      check({tag, " mem_wdata"}, cap_wdata, exp_mwdata);
    end
    check({tag, " rdata"}, rdata, exp_rdata);
    check({tag, " misaligned"}, 32'(misaligned), 32'(exp_mis));
    check({tag, " fault"}, 32'(fault), 32'(exp_fault));
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " rdata_clr"}, rdata, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst ready", 32'(ready), 32'd1);
    check("rst done", 32'(done), 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst ce", 32'(mem_ce), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst flags", {30'd0, misaligned, fault}, 32'd0);

    // Word store then load.
    txn("SW", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 3, 1'b1, 4'b1111, 32'h4, 32'hDEADBEEF,
        32'h0, 1'b0, 1'b0);
    txn("LW", 1'b0, 3'b010, 32'h10, 32'h0, 3, 1'b1, 4'b0000, 32'h4, 32'h0,
        32'hDEADBEEF, 1'b0, 1'b0);
    // Byte lane 3: word 4 becomes A5ADBEEF.
    txn("SB", 1'b1, 3'b000, 32'h13, 32'h000000A5, 3, 1'b1, 4'b1000, 32'h4, 32'hA5A5A5A5,
        32'h0, 1'b0, 1'b0);
    txn("LB", 1'b0, 3'b000, 32'h13, 32'h0, 3, 1'b1, 4'b0000, 32'h4, 32'h0,
        32'hFFFFFFA5, 1'b0, 1'b0);
    txn("LBU", 1'b0, 3'b100, 32'h13, 32'h0, 3, 1'b1, 4'b0000, 32'h4, 32'h0,
        32'h000000A5, 1'b0, 1'b0);
    // Upper half: word 8 becomes 80010000.
    txn("SH", 1'b1, 3'b001, 32'h22, 32'h00008001, 3, 1'b1, 4'b1100, 32'h8, 32'h80018001,
        32'h0, 1'b0, 1'b0);
    txn("LH", 1'b0, 3'b001, 32'h22, 32'h0, 3, 1'b1, 4'b0000, 32'h8, 32'h0,
        32'hFFFF8001, 1'b0, 1'b0);
    txn("LHU", 1'b0, 3'b101, 32'h22, 32'h0, 3, 1'b1, 4'b0000, 32'h8, 32'h0,
        32'h00008001, 1'b0, 1'b0);
    txn("LW_low_word", 1'b0, 3'b010, 32'h20, 32'h0, 3, 1'b1, 4'b0000, 32'h8, 32'h0,
        32'h80010000, 1'b0, 1'b0);

    // Rejected requests never touch the RAM.
    txn("LW_mis", 1'b0, 3'b010, 32'h06, 32'h0, 1, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    txn("LH_mis", 1'b0, 3'b001, 32'h05, 32'h0, 1, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    txn("SBU_ill", 1'b1, 3'b100, 32'h10, 32'h11, 1, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    txn("F3_011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Timeout: ISSUE + 8 WAIT cycles, DONE 10 cycles after accept.
    ram_mute = 1'b1;
    txn("LW_tmo", 1'b0, 3'b010, 32'h10, 32'h0, 10, 1'b1, 4'b0000, 32'h4, 32'h0,
        32'h0, 1'b0, 1'b1);
    ram_mute = 1'b0;
    txn("LW_after_tmo", 1'b0, 3'b010, 32'h10, 32'h0, 3, 1'b1, 4'b0000, 32'h4, 32'h0,
        32'hA5ADBEEF, 1'b0, 1'b0);

    // Reset in WAIT, then a stray VALID while idle.
    ram_mute = 1'b1;
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10;
    @(negedge clk);
    req = 1'b0;
    check("abort issue_ce", 32'(mem_ce), 32'd1);
    @(negedge clk);
    check("abort in_wait", 32'(ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ram_mute = 1'b0;
    check("abort ready", 32'(ready), 32'd1);
    check("abort done", 32'(done), 32'd0);
    check("abort outs", {27'd0, mem_ce, misaligned, fault, |mem_we, |rdata}, 32'd0);
    valid_inj = 1'b1;
    mem_rdata = 32'h12345678;
    @(negedge clk);
    valid_inj = 1'b0;
    check("late_valid done", 32'(done), 32'd0);
    check("late_valid ready", 32'(ready), 32'd1);
    @(negedge clk);
    check("late_valid done2", 32'(done), 32'd0);
    check("late_valid rdata", rdata, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
